// File: rtl/gray_counter.sv
// ============================================================================
// Module      : gray_counter
// Description : Registered WIDTH-bit binary/Gray up/down counter with
//               synchronous load and terminal-count pulse. Define
//               GRAY_CNT_SAT_EN for saturating instead of wrapping counts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             term
);

    localparam logic [WIDTH-1:0] c_all_ones = '1;
    localparam logic [WIDTH-1:0] c_zero     = '0;
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_term;

    logic             w_at_term;
    logic [WIDTH-1:0] w_step_bin;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_term;

    assign w_at_term  = up ? (r_bin == c_all_ones) : (r_bin == c_zero);
    assign w_step_bin = up ? (r_bin + c_one) : (r_bin - c_one);

    always_comb begin
        w_next_bin  = r_bin;
        w_next_term = 1'b0;
        if (load) begin
            w_next_bin = load_bin;
        end else if (en) begin
            w_next_term = w_at_term;
`ifdef GRAY_CNT_SAT_EN
            if (!w_at_term) begin
                w_next_bin = w_step_bin;
            end
`else
            w_next_bin = w_step_bin;
`endif
        end
    end

    // Gray is encoded from the next binary value so both flops update together.
    assign w_next_gray = w_next_bin ^ (w_next_bin >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_term <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_term <= w_next_term;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign term = r_term;

endmodule

`default_nettype wire

// File: tb/tb_gray_counter.sv
// ============================================================================
// Module      : tb_gray_counter
// Description : Self-checking bench for gray_counter (WIDTH 4 and 8 instances)
//               against a reference model using a reflected Gray code table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_counter;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en, up, load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin, gray;
    logic             term;

    logic             en8, up8, load8;
    logic [7:0]       load_bin8;
    logic [7:0]       bin8, gray8;
    logic             term8;

    int errors = 0;
    int checks = 0;
    int gtab [256];
    int mbin;
    int mterm;

    gray_counter #(.WIDTH(WIDTH)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
        .load_bin(load_bin), .bin(bin), .gray(gray), .term(term)
    );

    gray_counter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en8), .up(up8), .load(load8),
        .load_bin(load_bin8), .bin(bin8), .gray(gray8), .term(term8)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the 4-bit instance, then model update and compare.
    task automatic cycle(input logic l, input logic e, input logic u, input logic [WIDTH-1:0] lb);
        logic [WIDTH-1:0] prev_gray;
        bit moved;
        bit t;
        prev_gray = gray;
        moved = 0;
        load = l; en = e; up = u; load_bin = lb;
        @(posedge clk);
        if (l) begin
            mbin = lb;
            mterm = 0;
        end else if (e) begin
            t = u ? (mbin == MAXV) : (mbin == 0);
            mterm = t;
`ifdef GRAY_CNT_SAT_EN
            if (!t) begin
                mbin = u ? (mbin + 1) % (MAXV + 1) : (mbin + MAXV) % (MAXV + 1);
                moved = 1;
            end
`else
            mbin = u ? (mbin + 1) % (MAXV + 1) : (mbin + MAXV) % (MAXV + 1);
            moved = 1;
`endif
        end else begin
            mterm = 0;
        end
        #1;
        check("bin", bin, mbin);
        check("gray", gray, gtab[mbin]);
        check("term", term, mterm);
        check("gray_rel", gray, bin ^ (bin >> 1));
        if (moved) check("onebit", $countones(prev_gray ^ gray), 1);
    endtask

    initial begin
        gtab[0] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < (1 << k); i++)
                gtab[(1 << k) + i] = gtab[(1 << k) - 1 - i] | (1 << k);
        end

        rst = 1'b1; en = 0; up = 0; load = 0; load_bin = '0;
        en8 = 0; up8 = 0; load8 = 0; load_bin8 = '0;
        mbin = 0; mterm = 0;
        #12;
        check("rst_bin", bin, 0);
        check("rst_gray", gray, 0);
        check("rst_term", term, 0);
        rst = 1'b0;

        // asynchronous reset mid-cycle with bin = 9, en held across release
        cycle(1, 0, 1, 4'd9);
        #2 rst = 1'b1;
        en = 1'b1; up = 1'b1; load = 1'b0;
        #1;
        mbin = 0; mterm = 0;
        check("arst_bin", bin, 0);
        check("arst_gray", gray, 0);
        check("arst_term", term, 0);
        #2 rst = 1'b0;
        cycle(0, 1, 1, 4'd0);
        check("arst_first", gray, 4'b0001);

        // full up sweep from 0
        cycle(1, 0, 1, 4'd0);
        for (int i = 0; i < 16; i++) cycle(0, 1, 1, 4'd0);

        // down wrap
        cycle(1, 0, 0, 4'd0);
        cycle(0, 1, 0, 4'd0);
        cycle(0, 1, 0, 4'd0);

        // load beats enable
        cycle(1, 0, 1, 4'd5);
        cycle(1, 1, 1, 4'd12);
        check("load_gray", gray, 4'b1010);

        // terminal stepping up then direction change
        cycle(1, 0, 1, 4'd15);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 4'd0);
        cycle(0, 1, 0, 4'd0);

        // random stimulus
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(15) == 0), ($urandom_range(3) != 0),
                  1'($urandom_range(1)), 4'($urandom));
        end
        cycle(0, 0, 1, 4'd0);

        // 8-bit width scaling
        load8 = 1'b1; load_bin8 = 8'h7F;
        @(posedge clk); #1;
        check("w8_load_bin", bin8, 8'h7F);
        check("w8_load_gray", gray8, 8'h40);
        load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
        @(posedge clk); #1;
        check("w8_up_bin", bin8, 8'h80);
        check("w8_up_gray", gray8, 8'hC0);
        check("w8_up_term", term8, 0);
        up8 = 1'b0;
        @(posedge clk); #1;
        check("w8_dn_bin", bin8, 8'h7F);
        check("w8_dn_gray", gray8, gtab[8'h7F]);
        en8 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered binary/Gray up/down counter for the digital-lab code-conversion set. Generalises the fixed 4-bit combinational binary-to-Gray converter to WIDTH bits and adds a clocked count, synchronous load, direction control and a terminal-count pulse. Both binary and Gray values come straight from flops, so the Gray output is glitch-free and safe to sample in another clock domain. It feeds Gray-coded position or pointer values to downstream lab blocks (FIFO pointers, encoder demos).

## Interface
- WIDTH, default 4: counter width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; advances one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- load  input  1  synchronous load; has priority over en.
- load_bin  input  WIDTH  binary value taken on load.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin: gray = bin ^ (bin >> 1).
- term  output  1  registered one-cycle pulse flagging a step at the terminal value.

## Operation
- Next-state priority, evaluated each rising clk edge:
  1. load = 1: bin <= load_bin, term <= 0.
  2. en = 1 with no load: step in the direction given by up.
  3. Otherwise: hold, term <= 0.
- Step arithmetic is modulo 2^WIDTH, with no carry out.
- The terminal value is 2^WIDTH-1 when up = 1 and 0 when up = 0.
- term <= 1 on any step taken while bin equals the terminal value for the current up. term <= 0 on every other step.
- The gray register is loaded from the Gray encoding of the next bin value, in the same edge as bin. It is never derived combinationally from the bin output.
- Exactly one gray bit changes per step, including at wrap. A load may change any number of bits.
- Changing up between cycles is legal and takes effect on the next step.
- There is no internal state beyond bin, gray and term; no FSM.

## Timing
- Reset: while rst = 1, bin = 0, gray = 0, term = 0, independent of clk. The first step can occur on the first rising edge after rst deasserts.
- Reset asserted mid-count clears all outputs immediately. A load or step requested on the same edge is discarded.
- Latency:
  - en, up or load to bin/gray/term: 1 cycle (visible after the edge that samples them).
  - term is high for exactly one cycle per terminal step. If en stays high, the following step already starts from a non-terminal value.
- load and en both high: the load wins, term = 0, and no step occurs that cycle.
- Every output is driven from a flop, with no combinational path from any input to any output.

## Configuration
- GRAY_CNT_SAT_EN not defined (default): wrap-around counting. At the terminal value a step wraps (2^WIDTH-1 -> 0 up, 0 -> 2^WIDTH-1 down) and term pulses.
- GRAY_CNT_SAT_EN defined: saturating counting. At the terminal value a step leaves bin and gray unchanged and term still pulses for one cycle. All other steps, loads and reset behave as in the default build.

## Test plan
- Reset: assert rst asynchronously mid-cycle with bin = 9 -> bin = 0, gray = 0 and term = 0 before the next edge. Hold en = 1 across release -> the first edge after release gives bin = 1, gray = 0001.
- Full up sweep, WIDTH = 4, en = 1, up = 1, 16 cycles from 0:
  - gray follows 0000, 0001, 0011, 0010, ... 1000, then 0000.
  - Exactly one gray bit changes per cycle.
  - term is high only on the cycle after the 15 -> 0 step.
- Down wrap: load 0, then en = 1, up = 0 -> bin = 15, gray = 1000, term = 1 for one cycle. Next step: bin = 14, gray = 1001, term = 0.
- Load priority: bin = 5, load = 1 with load_bin = 12 and en = 1 in the same cycle -> bin = 12, gray = 1010, term = 0, no step.
- Saturation (GRAY_CNT_SAT_EN defined): load 15, en = 1, up = 1 for 3 cycles -> bin stays 15, gray stays 1000, term = 1 on each cycle. Switch up = 0 -> bin = 14, term = 0.
- Width scaling, WIDTH = 8: load 8'h7F, step up -> bin = 8'h80, gray = 8'hC0. Checker confirms gray == bin ^ (bin >> 1) on every cycle.
